// File: rtl/fifo_fwft_adapter.sv
// Standard-FIFO read port to first-word-fall-through adapter.
// Output register plus one skid register allow a pop every cycle.
module fifo_fwft_adapter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    input  logic             rden,
    output logic [1:0]       level
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             inflight_q;
    logic             pop;
    logic [1:0]       occ;

    assign pop   = rden & out_valid_q;
    assign empty = ~out_valid_q;
    assign dout  = out_data_q;
    assign level = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

    // Words held or arriving, after this cycle's pop; never exceeds 3.
    assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q}
               + {1'b0, inflight_q} - {1'b0, pop};

    assign fifo_rd_en = ~rst & ~fifo_empty & ~occ[1];

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (pop) begin
            if (skid_valid_q) begin
                out_data_d = skid_data_q;
                if (inflight_q) begin
                    skid_data_d = fifo_dout;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (inflight_q) begin
                out_data_d = fifo_dout;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = fifo_dout;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = fifo_dout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            inflight_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            inflight_q   <= fifo_rd_en;
        end
    end

endmodule

// File: doc/fifo_fwft_adapter.md
Name: fifo_fwft_adapter

Overview:
Converts the standard read port of a FIFO (read data valid one cycle after the read strobe) into a first-word-fall-through (FWFT) read port. The FWFT port presents the head word on dout whenever empty is low, and rden acknowledges that word. The block sits between a standard synchronous FIFO and any FWFT consumer, including the FWFT reader bench model. It holds up to two words (output register plus skid register) so the consumer can pop one word per cycle with no bubbles.

Parameters:
WIDTH, 32, data word width in bits (must be >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
fifo_rd_en  output  1  read strobe to upstream standard FIFO (combinational)
fifo_dout  input  WIDTH  upstream read data; valid the cycle after an accepted fifo_rd_en
fifo_empty  input  1  upstream empty flag
dout  output  WIDTH  FWFT head word; valid while empty=0
empty  output  1  FWFT empty flag; high = no word presented
rden  input  1  FWFT pop; consumes dout at the rising edge when empty=0
level  output  2  words held locally (0..2), excluding any in-flight read

Behaviour:
- State:
  - out_valid / out_data: the head word.
  - skid_valid / skid_data: the next word.
  - inflight: a read was issued last cycle and its data arrives this cycle.
- Reset (async, rst=1): out_valid=0, skid_valid=0, inflight=0, dout=0, skid_data=0.
  - Outputs during reset: empty=1, level=0, fifo_rd_en=0 (gated with rst).
- Derived signals:
  - empty = ~out_valid
  - level = out_valid + skid_valid
  - pop = rden & out_valid
- Read issue rule: fifo_rd_en = ~rst & ~fifo_empty & ((out_valid + skid_valid + inflight - pop) < 2).
  - inflight_next = fifo_rd_en.
- Arrival (inflight=1): capture fifo_dout at the edge.
  - It goes to the output register if the output becomes free this cycle (out_valid=0, or pop with skid_valid=0).
  - Otherwise it goes to the skid register.
- Pop:
  - If skid_valid: skid moves to the output register; a simultaneous arrival goes to skid.
  - Else the output register takes the arrival if present, otherwise out_valid clears.
- Ordering: strict FIFO order is preserved; no word is duplicated or dropped.
- Skid overflow is impossible by construction. The bench asserts that skid_valid & inflight & ~pop never writes over a valid skid.
- rden while empty=1: ignored; no state change and no error.
- Latency: first cycle with fifo_empty=0 (cycle N, FWFT side idle) gives fifo_rd_en=1 in N, data captured at the end of N+1, empty=0 and dout valid in N+2.
- Throughput: with the upstream never empty and rden held high, one word is popped every cycle from N+2 onward.
- Backpressure: with rden=0, at most 2 words are held plus 0 in flight. fifo_rd_en stays low while level=2.
- dout holds its value when empty=1 after a pop (it is not cleared). Consumers must ignore dout while empty=1.
- Reset mid-operation: all local and in-flight words are discarded. The upstream FIFO must share the same rst.
- Upstream contract: fifo_rd_en is issued only when fifo_empty=0, so the upstream FIFO never sees an underflow read.

Test Plan:
- Reset, then load the upstream with 0x11 at cycle 0 -> fifo_rd_en=1 in cycle 0, empty=0 and dout=0x11 at cycle 2, level=1.
- Upstream holds 0x01..0x10, rden tied high -> dout steps through 0x01..0x10 on consecutive cycles with no bubble, then empty=1. Exactly 16 fifo_rd_en pulses.
- Upstream holds 0xA..0xF, rden=0 -> exactly 2 reads issued, level=2, dout=0xA, fifo_rd_en low thereafter. Then a single rden pulse -> dout=0xB next cycle and one new read is issued.
- Random rden (50% rate) against a random-rate upstream writer, 1000 words with incrementing pattern -> output sequence is exactly 0..999, and no read is issued while fifo_empty=1.
- rden asserted while empty=1 for 5 cycles -> no state change, level=0, no fifo_rd_en.
- rst asserted with level=2 and a read in flight -> empty=1, level=0, dout=0 immediately (async). After release with the upstream reset too, new data 0x55 appears at dout within 2 cycles.
